wb_queue: RTL and testbench

- Parametrised successor to the single-entry MEM/WB register: a DEPTH-entry FIFO of pending register-file writebacks between the MEM stage and the register file write port.
- Decouples MEM from a write port that is not always available (wb_ready), so MEM is not stalled on every port conflict.
- Drops non-writing results and x0 writes at entry.
- Provides youngest-match forwarding of queued data to ID.

---
 rtl/wb_queue.sv | 96 +++++++++
 tb/tb_wb_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue between MEM and the register-file write port: a DEPTH-entry FIFO
// of pending register writes with youngest-match forwarding to ID.
module wb_queue #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              in_ready,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              stall_req
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              empty;
  logic              eq;
  logic              dq;
  logic [PTR_W-1:0]  scan_idx;

  always_comb begin
    empty     = (count == '0);
    in_ready  = rdy && ((count < CNT_W'(DEPTH)) || wb_ready);
    stall_req = in_valid && !in_ready;
    wb_we     = rdy && !empty;
    wb_waddr  = empty ? '0 : addr_mem[head];
    wb_wdata  = empty ? '0 : data_mem[head];
    eq        = in_valid && in_ready && in_we && (in_waddr != '0);
    dq        = wb_we && wb_ready;
  end

  // Oldest-to-youngest scan; later hits overwrite earlier ones, so the youngest wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (valid[scan_idx] && (addr_mem[scan_idx] == fwd_raddr) && (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[scan_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (dq) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      // When full, head == tail on push+pop; the later set must win over the clear.
      if (eq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      case ({eq, dq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && eq) begin
      addr_mem[tail] <= in_waddr;
      data_mem[tail] <= in_wdata;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scenario bench for wb_queue: expected retirements are queued as stimulus is driven
// and compared against writes captured from the write port.
module tb_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [ADDR_W+DATA_W-1:0] ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              in_valid;
  logic              in_we;
  logic [ADDR_W-1:0] in_waddr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_ready;
  logic              wb_ready;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;
  logic              stall_req;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   obs_mark = 0;
  int   tests = 0;
  int   fails = 0;

  wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_ready(in_ready), .wb_ready(wb_ready),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Capture every write that retires at the following rising edge.
  always @(negedge clk)
    if (!rst && rdy && wb_we && wb_ready) obs_q.push_back({wb_waddr, wb_wdata});

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    in_valid = v;
    in_we    = we;
    in_waddr = a;
    in_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; wb_ready = 1'b0; fwd_raddr = '0;
    drive(1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
    obs_mark = obs_q.size();
  endtask

  task automatic test_reset();
    do_reset();
    wb_ready = 1'b1; fwd_raddr = 5'd5;
    @(negedge clk);
    tests++; if (count !== '0)      begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    tests++; if (wb_we !== 1'b0)    begin fails++; $display("FAIL rst_wb_we got %0b exp 0", wb_we); end
    tests++; if (wb_waddr !== '0)   begin fails++; $display("FAIL rst_wb_waddr got %0d exp 0", wb_waddr); end
    tests++; if (wb_wdata !== '0)   begin fails++; $display("FAIL rst_wb_wdata got %h exp 0", wb_wdata); end
    tests++; if (fwd_hit !== 1'b0)  begin fails++; $display("FAIL rst_fwd_hit got %0b exp 0", fwd_hit); end
    tests++; if (fwd_data !== '0)   begin fails++; $display("FAIL rst_fwd_data got %h exp 0", fwd_data); end
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_stall got %0b exp 0", stall_req); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    wb_ready = 1'b1; fwd_raddr = 5'd5;
    drive(1'b1, 1'b1, 5'd5, 32'h11);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready got %0b exp 1", in_ready); end
    tests++; if (wb_we !== 1'b0)    begin fails++; $display("FAIL single_bypass got wb_we %0b exp 0", wb_we); end
    tests++; if (fwd_hit !== 1'b0)  begin fails++; $display("FAIL single_fwd_incoming got %0b exp 0", fwd_hit); end
    exp_q.push_back({5'd5, 32'h11});
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++; if (wb_we !== 1'b1)      begin fails++; $display("FAIL single_wb_we got %0b exp 1", wb_we); end
    tests++; if (wb_waddr !== 5'd5)   begin fails++; $display("FAIL single_wb_waddr got %0d exp 5", wb_waddr); end
    tests++; if (wb_wdata !== 32'h11) begin fails++; $display("FAIL single_wb_wdata got %h exp 11", wb_wdata); end
    tests++; if (count !== 3'd1)      begin fails++; $display("FAIL single_count got %0d exp 1", count); end
    tests++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11)
      begin fails++; $display("FAIL single_fwd got %0b/%h exp 1/11", fwd_hit, fwd_data); end
    next_cycle();
    @(negedge clk);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL single_count_after got %0d exp 0", count); end
    tests++; if (wb_we !== 1'b0) begin fails++; $display("FAIL single_wb_we_after got %0b exp 0", wb_we); end
    foreach (exp_q[i]) begin
      tests++;
      if (obs_mark + i >= obs_q.size()) begin fails++; $display("FAIL single_retire[%0d] got none exp %h", i, exp_q[i]); end
      else if (obs_q[obs_mark+i] !== exp_q[i]) begin fails++; $display("FAIL single_retire[%0d] got %h exp %h", i, obs_q[obs_mark+i], exp_q[i]); end
    end
    tests++; if (obs_q.size() - obs_mark != exp_q.size())
      begin fails++; $display("FAIL single_retire_count got %0d exp %0d", obs_q.size() - obs_mark, exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, ADDR_W'(i), DATA_W'(32'hA0 + i));
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_in_ready[%0d] got %0b exp 1", i, in_ready); end
      exp_q.push_back({ADDR_W'(i), DATA_W'(32'hA0 + i)});
      next_cycle();
    end
    drive(1'b1, 1'b1, 5'd6, 32'hA5);
    @(negedge clk);
    tests++; if (count !== 3'd4)       begin fails++; $display("FAIL fill_count got %0d exp 4", count); end
    tests++; if (in_ready !== 1'b0)    begin fails++; $display("FAIL fill_full_in_ready got %0b exp 0", in_ready); end
    tests++; if (stall_req !== 1'b1)   begin fails++; $display("FAIL fill_full_stall got %0b exp 1", stall_req); end
    next_cycle();
    wb_ready = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL fill_release_in_ready got %0b exp 1", in_ready); end
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL fill_release_stall got %0b exp 0", stall_req); end
    exp_q.push_back({5'd6, 32'hA5});
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    repeat (6) next_cycle();
    @(negedge clk);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL fill_drained got %0d exp 0", count); end
    foreach (exp_q[i]) begin
      tests++;
      if (obs_mark + i >= obs_q.size()) begin fails++; $display("FAIL fill_retire[%0d] got none exp %h", i, exp_q[i]); end
      else if (obs_q[obs_mark+i] !== exp_q[i]) begin fails++; $display("FAIL fill_retire[%0d] got %h exp %h", i, obs_q[obs_mark+i], exp_q[i]); end
    end
    tests++; if (obs_q.size() - obs_mark != exp_q.size())
      begin fails++; $display("FAIL fill_retire_count got %0d exp %0d", obs_q.size() - obs_mark, exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, ADDR_W'(i + 1), DATA_W'(32'hB0 + i));
      exp_q.push_back({ADDR_W'(i + 1), DATA_W'(32'hB0 + i)});
      next_cycle();
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, ADDR_W'(i + 10), DATA_W'(32'hC0 + i));
      @(negedge clk);
      tests++; if (count !== 3'd4 || in_ready !== 1'b1 || wb_we !== 1'b1)
        begin fails++; $display("FAIL b2b_state[%0d] got count %0d rdy %0b we %0b exp 4 1 1", i, count, in_ready, wb_we); end
      exp_q.push_back({ADDR_W'(i + 10), DATA_W'(32'hC0 + i)});
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0);
    repeat (6) next_cycle();
    @(negedge clk);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drained got %0d exp 0", count); end
    foreach (exp_q[i]) begin
      tests++;
      if (obs_mark + i >= obs_q.size()) begin fails++; $display("FAIL b2b_retire[%0d] got none exp %h", i, exp_q[i]); end
      else if (obs_q[obs_mark+i] !== exp_q[i]) begin fails++; $display("FAIL b2b_retire[%0d] got %h exp %h", i, obs_q[obs_mark+i], exp_q[i]); end
    end
    tests++; if (obs_q.size() - obs_mark != exp_q.size())
      begin fails++; $display("FAIL b2b_retire_count got %0d exp %0d", obs_q.size() - obs_mark, exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_forward();
    logic [ADDR_W-1:0] push_a [3] = '{5'd7, 5'd3, 5'd7};
    logic [DATA_W-1:0] push_d [3] = '{32'h1, 32'h2, 32'h3};
    logic [ADDR_W-1:0] rd_a [4]   = '{5'd7, 5'd3, 5'd0, 5'd9};
    logic              rd_hit [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [DATA_W-1:0] rd_d [4]   = '{32'h3, 32'h2, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, push_a[i], push_d[i]);
      exp_q.push_back({push_a[i], push_d[i]});
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      fwd_raddr = rd_a[i];
      @(negedge clk);
      tests++; if (fwd_hit !== rd_hit[i] || fwd_data !== rd_d[i])
        begin fails++; $display("FAIL fwd_x%0d got %0b/%h exp %0b/%h", rd_a[i], fwd_hit, fwd_data, rd_hit[i], rd_d[i]); end
      next_cycle();
    end
    wb_ready = 1'b1; fwd_raddr = 5'd3;
    next_cycle();
    @(negedge clk);
    tests++; if (wb_waddr !== 5'd3 || fwd_hit !== 1'b1 || fwd_data !== 32'h2)
      begin fails++; $display("FAIL fwd_retiring got head %0d %0b/%h exp 3 1/2", wb_waddr, fwd_hit, fwd_data); end
    next_cycle();
    @(negedge clk);
    tests++; if (fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_after_retire got %0b exp 0", fwd_hit); end
    repeat (3) next_cycle();
    foreach (exp_q[i]) begin
      tests++;
      if (obs_mark + i >= obs_q.size()) begin fails++; $display("FAIL fwd_retire[%0d] got none exp %h", i, exp_q[i]); end
      else if (obs_q[obs_mark+i] !== exp_q[i]) begin fails++; $display("FAIL fwd_retire[%0d] got %h exp %h", i, obs_q[obs_mark+i], exp_q[i]); end
    end
    tests++; if (obs_q.size() - obs_mark != exp_q.size())
      begin fails++; $display("FAIL fwd_retire_count got %0d exp %0d", obs_q.size() - obs_mark, exp_q.size()); end
  endtask

  task automatic test_filter();
    do_reset();
    wb_ready = 1'b1;
    drive(1'b1, 1'b0, 5'd4, 32'h44);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL filter_nowe_ready got %0b exp 1", in_ready); end
    next_cycle();
    drive(1'b1, 1'b1, 5'd0, 32'h55);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL filter_x0_ready got %0b exp 1", in_ready); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (count !== 3'd0 || wb_we !== 1'b0)
        begin fails++; $display("FAIL filter_empty[%0d] got count %0d we %0b exp 0 0", i, count, wb_we); end
      next_cycle();
    end
    tests++; if (obs_q.size() != obs_mark)
      begin fails++; $display("FAIL filter_retire_count got %0d exp 0", obs_q.size() - obs_mark); end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    drive(1'b1, 1'b1, 5'd2, 32'hD1); exp_q.push_back({5'd2, 32'hD1}); next_cycle();
    drive(1'b1, 1'b1, 5'd5, 32'hD2); exp_q.push_back({5'd5, 32'hD2}); next_cycle();
    drive(1'b1, 1'b1, 5'd8, 32'hDD);
    rdy = 1'b0; wb_ready = 1'b1; fwd_raddr = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (count !== 3'd2 || wb_we !== 1'b0 || stall_req !== 1'b1 || in_ready !== 1'b0)
        begin fails++; $display("FAIL freeze_state[%0d] got count %0d we %0b stall %0b rdy %0b exp 2 0 1 0", i, count, wb_we, stall_req, in_ready); end
      tests++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hD2)
        begin fails++; $display("FAIL freeze_fwd[%0d] got %0b/%h exp 1/d2", i, fwd_hit, fwd_data); end
      next_cycle();
    end
    rdy = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++; if (wb_we !== 1'b1 || wb_waddr !== 5'd2 || wb_wdata !== 32'hD1)
      begin fails++; $display("FAIL freeze_resume got %0b %0d %h exp 1 2 d1", wb_we, wb_waddr, wb_wdata); end
    repeat (4) next_cycle();
    @(negedge clk);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL freeze_drained got %0d exp 0", count); end
    foreach (exp_q[i]) begin
      tests++;
      if (obs_mark + i >= obs_q.size()) begin fails++; $display("FAIL freeze_retire[%0d] got none exp %h", i, exp_q[i]); end
      else if (obs_q[obs_mark+i] !== exp_q[i]) begin fails++; $display("FAIL freeze_retire[%0d] got %h exp %h", i, obs_q[obs_mark+i], exp_q[i]); end
    end
    tests++; if (obs_q.size() - obs_mark != exp_q.size())
      begin fails++; $display("FAIL freeze_retire_count got %0d exp %0d", obs_q.size() - obs_mark, exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, ADDR_W'(i), DATA_W'(32'hE0 + i));
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL rstmid_count_before got %0d exp 3", count); end
    rst = 1'b1; rdy = 1'b0;
    next_cycle();
    rst = 1'b0; rdy = 1'b1; wb_ready = 1'b1; fwd_raddr = 5'd1;
    @(negedge clk);
    tests++; if (count !== 3'd0 || wb_we !== 1'b0 || fwd_hit !== 1'b0)
      begin fails++; $display("FAIL rstmid_after got count %0d we %0b hit %0b exp 0 0 0", count, wb_we, fwd_hit); end
    next_cycle();
    @(negedge clk);
    tests++; if (wb_we !== 1'b0) begin fails++; $display("FAIL rstmid_idle got %0b exp 0", wb_we); end
    tests++; if (obs_q.size() != obs_mark)
      begin fails++; $display("FAIL rstmid_retire_count got %0d exp 0", obs_q.size() - obs_mark); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_forward();
    test_filter();
    test_rdy_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
